// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: single-beat decode, byte/half/word access to an inferred
// RAM, optional wait states and the two-cycle ERROR response for illegal accesses.
module ahb_lite_sram_slave #(
    parameter int unsigned                AHB_ADDR_WIDTH = 32,
    parameter int unsigned                AHB_DATA_WIDTH = 32,
    parameter int unsigned                MEM_SIZE_BYTES = 65536,
    parameter logic [AHB_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
    parameter int unsigned                WAIT_STATES    = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      hsel_i,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
    input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
    input  logic                      hwrite_i,
    input  logic [2:0]                hsize_i,
    input  logic [2:0]                hburst_i,
    input  logic [3:0]                hprot_i,
    input  logic [1:0]                htrans_i,
    input  logic                      hmastlock_i,
    input  logic                      hready_i,
    output logic [AHB_DATA_WIDTH-1:0] hrdata_o,
    output logic                      hreadyout_o,
    output logic                      hresp_o
);

    localparam int unsigned BYTE_ADDR_W = $clog2(MEM_SIZE_BYTES);
    localparam int unsigned IDX_W       = (BYTE_ADDR_W > 2) ? BYTE_ADDR_W - 2 : 1;
    localparam int unsigned DEPTH       = 1 << IDX_W;
    localparam logic [AHB_ADDR_WIDTH-1:0] MEM_LIMIT = AHB_ADDR_WIDTH'(MEM_SIZE_BYTES);
    localparam logic [3:0]  WS_INIT     = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                      state;
    logic [3:0]                  wait_cnt;
    logic                        wr_pend;
    logic                        rd_pend;
    logic [IDX_W-1:0]            wr_idx;
    logic [3:0]                  wr_strb;
    logic [AHB_DATA_WIDTH-1:0]   rd_buf;
    logic [AHB_DATA_WIDTH-1:0]   mem [DEPTH];

    logic                        accept;
    logic                        illegal;
    logic                        misaligned;
    logic [AHB_ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]            acc_idx;
    logic [3:0]                  acc_strb;
    logic                        wr_commit;
    logic [AHB_DATA_WIDTH-1:0]   rd_word;

    // Burst type, protection and lock carry no meaning for this memory.
    logic unused_inputs;
    assign unused_inputs = ^{hburst_i, hprot_i, hmastlock_i};

    assign accept     = hsel_i & hready_i & htrans_i[1];
    assign offset     = haddr_i - BASE_ADDR;
    assign acc_idx    = IDX_W'(haddr_i >> 2);
    assign wr_commit  = (state == ST_DATA) && wr_pend;

    // Address-phase decode: legality check and byte-lane strobes.
    always_comb begin
        misaligned = 1'b0;
        acc_strb   = 4'hF;
        case (hsize_i)
            3'd0: acc_strb = 4'b0001 << haddr_i[1:0];
            3'd1: begin
                acc_strb   = 4'b0011 << haddr_i[1:0];
                misaligned = haddr_i[0];
            end
            3'd2: misaligned = (haddr_i[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        illegal = (offset >= MEM_LIMIT) || (hsize_i > 3'd2) || misaligned;
    end

    // Read word for the accepted address, with bytes of a write completing on the
    // same edge forwarded so back-to-back write/read to one word sees the new data.
    always_comb begin
        rd_word = mem[acc_idx];
        if (wr_commit && (wr_idx == acc_idx)) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    rd_word[8*i +: 8] = hwdata_i[8*i +: 8];
                end
            end
        end
    end

    // Bus FSM with registered handshake, response and read data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            hreadyout_o <= 1'b1;
            hresp_o     <= 1'b0;
            hrdata_o    <= '0;
            wait_cnt    <= '0;
            wr_pend     <= 1'b0;
            rd_pend     <= 1'b0;
            wr_idx      <= '0;
            wr_strb     <= '0;
            rd_buf      <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state       <= ST_DATA;
                        hreadyout_o <= 1'b1;
                        if (rd_pend) begin
                            hrdata_o <= rd_buf;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_o <= 1'b1;
                    hresp_o     <= 1'b1;
                end
                default: begin
                    if (accept && illegal) begin
                        state       <= ST_ERR1;
                        hreadyout_o <= 1'b0;
                        hresp_o     <= 1'b1;
                        wr_pend     <= 1'b0;
                        rd_pend     <= 1'b0;
                    end else if (accept) begin
                        wr_pend <= hwrite_i;
                        rd_pend <= !hwrite_i;
                        wr_idx  <= acc_idx;
                        wr_strb <= acc_strb;
                        hresp_o <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state       <= ST_DATA;
                            hreadyout_o <= 1'b1;
                            if (!hwrite_i) begin
                                hrdata_o <= rd_word;
                            end
                        end else begin
                            // Read is sampled now (no other write can land during
                            // the stall) and presented when the data phase ends.
                            state       <= ST_WAIT;
                            hreadyout_o <= 1'b0;
                            wait_cnt    <= WS_INIT;
                            rd_buf      <= rd_word;
                        end
                    end else begin
                        state       <= ST_IDLE;
                        hreadyout_o <= 1'b1;
                        hresp_o     <= 1'b0;
                        wr_pend     <= 1'b0;
                        rd_pend     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // RAM byte-lane write at the edge ending a write data phase; reset drops it.
    always_ff @(posedge clk) begin
        if (rstn && wr_commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= hwdata_i[8*i +: 8];
                end
            end
        end
    end

endmodule
